// File: rtl/parameter_bank_pkg.sv
// Shared types for the per-channel synthesis parameter store.
// Covers the CC number map, the parameter record with its defaults, and the slew FSM states.
package parameter_bank_pkg;

  localparam int DATA_WIDTH  = 7;
  localparam int FIELD_WIDTH = 8;

  typedef logic [FIELD_WIDTH-1:0] field_t;

  typedef struct packed {
    field_t volume;
    field_t unison_detune;
    field_t attack_time;
    field_t decay_time;
    field_t sustain_level;
    field_t release_time;
    field_t duty_cycle;
  } parameter_t;

  typedef enum logic [2:0] {
    PARAM_NONE,
    PARAM_VOLUME,
    PARAM_UNISON_DETUNE,
    PARAM_ATTACK_TIME,
    PARAM_DECAY_TIME,
    PARAM_SUSTAIN_LEVEL,
    PARAM_RELEASE_TIME,
    PARAM_DUTY_CYCLE
  } parameter_change_t;

  typedef enum logic {IDLE, SCAN} slew_state_t;

  localparam parameter_t DEFAULT_PARAMETERS = '{
    volume:        8'h40,
    unison_detune: 8'h00,
    attack_time:   8'h00,
    decay_time:    8'h00,
    sustain_level: 8'h7F,
    release_time:  8'h00,
    duty_cycle:    8'h40
  };

  localparam logic [DATA_WIDTH-1:0] CC_VOLUME        = 7'd7;
  localparam logic [DATA_WIDTH-1:0] CC_UNISON_DETUNE = 7'd94;
  localparam logic [DATA_WIDTH-1:0] CC_ATTACK_TIME   = 7'd73;
  localparam logic [DATA_WIDTH-1:0] CC_DECAY_TIME    = 7'd75;
  localparam logic [DATA_WIDTH-1:0] CC_SUSTAIN_LEVEL = 7'd79;
  localparam logic [DATA_WIDTH-1:0] CC_RELEASE_TIME  = 7'd72;
  localparam logic [DATA_WIDTH-1:0] CC_DUTY_CYCLE    = 7'd70;
  localparam logic [DATA_WIDTH-1:0] CC_RESET_ALL     = 7'd121;

  // Reset-all and unknown controllers both map to PARAM_NONE; callers tell them apart.
  function automatic parameter_change_t cc_to_param(input logic [DATA_WIDTH-1:0] num);
    parameter_change_t p;
    case (num)
      CC_VOLUME:        p = PARAM_VOLUME;
      CC_UNISON_DETUNE: p = PARAM_UNISON_DETUNE;
      CC_ATTACK_TIME:   p = PARAM_ATTACK_TIME;
      CC_DECAY_TIME:    p = PARAM_DECAY_TIME;
      CC_SUSTAIN_LEVEL: p = PARAM_SUSTAIN_LEVEL;
      CC_RELEASE_TIME:  p = PARAM_RELEASE_TIME;
      CC_DUTY_CYCLE:    p = PARAM_DUTY_CYCLE;
      default:          p = PARAM_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/parameter_bank_if.sv
// CC input stream and change-event output stream of the parameter bank.
interface parameter_bank_if;
  import parameter_bank_pkg::*;

  logic                    cc_valid;
  logic                    cc_ready;
  logic [3:0]              cc_channel;
  logic [DATA_WIDTH-1:0]   cc_number;
  logic [DATA_WIDTH-1:0]   cc_value;
  logic                    change_valid;
  logic                    change_ready;
  logic [3:0]              change_channel;
  parameter_change_t       change_param;

  modport master (
    output cc_valid, cc_channel, cc_number, cc_value, change_ready,
    input  cc_ready, change_valid, change_channel, change_param
  );

  modport slave (
    input  cc_valid, cc_channel, cc_number, cc_value, change_ready,
    output cc_ready, change_valid, change_channel, change_param
  );
endinterface

// File: rtl/param_slew.sv
// One slew step for a single 8-bit level field: move toward tgt by at most SLEW_STEP, never past it.
module param_slew
  import parameter_bank_pkg::*;
#(
  parameter int SLEW_STEP = 4
) (
  input  field_t cur,
  input  field_t tgt,
  output field_t next
);
  localparam field_t STEP = field_t'(SLEW_STEP);

  field_t diff;

  always_comb begin
    diff = '0;
    next = cur;
    if (cur < tgt) begin
      diff = tgt - cur;
      next = cur + ((diff > STEP) ? STEP : diff);
    end else if (cur > tgt) begin
      diff = cur - tgt;
      next = cur - ((diff > STEP) ? STEP : diff);
    end
  end
endmodule

// File: rtl/parameter_bank.sv
// Per-channel CC-driven parameter store; level fields glide toward their targets,
// one channel per cycle after every slew tick, and accepted changes are reported on a one-entry event stream.
module parameter_bank
  import parameter_bank_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SLEW_STEP    = 4,
  parameter int SLEW_DIV     = 256
) (
  input  logic                          clock,
  input  logic                          reset,
  parameter_bank_if.slave               bus,
  output parameter_t [NUM_CHANNELS-1:0] params
);
  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLEW_DIV - 1);

  if (SLEW_DIV < NUM_CHANNELS || NUM_CHANNELS < 1 || NUM_CHANNELS > 16 ||
      SLEW_STEP < 1 || SLEW_STEP > 127) begin : g_param_check
    $error("parameter_bank: bad NUM_CHANNELS/SLEW_STEP/SLEW_DIV combination");
  end

  parameter_t [NUM_CHANNELS-1:0] tgt_q, tgt_d, cur_q, cur_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick;
  slew_state_t       state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              ev_valid_q, ev_valid_d;
  logic [3:0]        ev_channel_q, ev_channel_d;
  parameter_change_t ev_param_q, ev_param_d;

  field_t scan_cur_vol, scan_tgt_vol, scan_cur_sus, scan_tgt_sus, scan_cur_duty, scan_tgt_duty;
  field_t vol_next, sus_next, duty_next;
  logic   cc_fire, cc_in_range, cc_reset_all;
  parameter_change_t cc_param;
  field_t cc_field;

  assign bus.cc_ready       = !reset && (!ev_valid_q || bus.change_ready);
  assign bus.change_valid   = ev_valid_q;
  assign bus.change_channel = ev_channel_q;
  assign bus.change_param   = ev_param_q;
  assign params             = cur_q;

  assign cc_fire      = bus.cc_valid && bus.cc_ready;
  assign cc_in_range  = int'(bus.cc_channel) < NUM_CHANNELS;
  assign cc_reset_all = bus.cc_number == CC_RESET_ALL;
  assign cc_param     = cc_to_param(bus.cc_number);
  assign cc_field     = field_t'(bus.cc_value);

  assign tick  = div_q == DIV_LAST;
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  always_comb begin
    scan_cur_vol  = cur_q[0].volume;
    scan_tgt_vol  = tgt_q[0].volume;
    scan_cur_sus  = cur_q[0].sustain_level;
    scan_tgt_sus  = tgt_q[0].sustain_level;
    scan_cur_duty = cur_q[0].duty_cycle;
    scan_tgt_duty = tgt_q[0].duty_cycle;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (idx_q == IDX_W'(c)) begin
        scan_cur_vol  = cur_q[c].volume;
        scan_tgt_vol  = tgt_q[c].volume;
        scan_cur_sus  = cur_q[c].sustain_level;
        scan_tgt_sus  = tgt_q[c].sustain_level;
        scan_cur_duty = cur_q[c].duty_cycle;
        scan_tgt_duty = tgt_q[c].duty_cycle;
      end
    end
  end

  param_slew #(.SLEW_STEP(SLEW_STEP)) u_slew_vol  (.cur(scan_cur_vol),  .tgt(scan_tgt_vol),  .next(vol_next));
  param_slew #(.SLEW_STEP(SLEW_STEP)) u_slew_sus  (.cur(scan_cur_sus),  .tgt(scan_tgt_sus),  .next(sus_next));
  param_slew #(.SLEW_STEP(SLEW_STEP)) u_slew_duty (.cur(scan_cur_duty), .tgt(scan_tgt_duty), .next(duty_next));

  // Scan update is applied first so a same-cycle reset-all overrides it.
  always_comb begin
    tgt_d = tgt_q;
    cur_d = cur_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state_q == SCAN && idx_q == IDX_W'(c)) begin
        cur_d[c].volume        = vol_next;
        cur_d[c].sustain_level = sus_next;
        cur_d[c].duty_cycle    = duty_next;
      end
      if (cc_fire && bus.cc_channel == 4'(c)) begin
        if (cc_reset_all) begin
          tgt_d[c] = DEFAULT_PARAMETERS;
          cur_d[c] = DEFAULT_PARAMETERS;
        end else begin
          case (cc_param)
            PARAM_VOLUME:        tgt_d[c].volume        = cc_field;
            PARAM_SUSTAIN_LEVEL: tgt_d[c].sustain_level = cc_field;
            PARAM_DUTY_CYCLE:    tgt_d[c].duty_cycle    = cc_field;
            PARAM_UNISON_DETUNE: begin
              tgt_d[c].unison_detune = cc_field;
              cur_d[c].unison_detune = cc_field;
            end
            PARAM_ATTACK_TIME: begin
              tgt_d[c].attack_time = cc_field;
              cur_d[c].attack_time = cc_field;
            end
            PARAM_DECAY_TIME: begin
              tgt_d[c].decay_time = cc_field;
              cur_d[c].decay_time = cc_field;
            end
            PARAM_RELEASE_TIME: begin
              tgt_d[c].release_time = cc_field;
              cur_d[c].release_time = cc_field;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    ev_valid_d   = ev_valid_q && !bus.change_ready;
    ev_channel_d = ev_channel_q;
    ev_param_d   = ev_param_q;
    if (cc_fire && cc_in_range && (cc_reset_all || cc_param != PARAM_NONE)) begin
      ev_valid_d   = 1'b1;
      ev_channel_d = bus.cc_channel;
      ev_param_d   = cc_param;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        tgt_q[c] <= DEFAULT_PARAMETERS;
        cur_q[c] <= DEFAULT_PARAMETERS;
      end
      div_q        <= '0;
      ev_valid_q   <= 1'b0;
      ev_channel_q <= '0;
      ev_param_q   <= PARAM_NONE;
    end else begin
      tgt_q        <= tgt_d;
      cur_q        <= cur_d;
      div_q        <= div_d;
      ev_valid_q   <= ev_valid_d;
      ev_channel_q <= ev_channel_d;
      ev_param_q   <= ev_param_d;
    end
  end

  // IDLE waits for a tick; SCAN steps channel idx_q and restarts at once if a tick lands on the last channel.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= SCAN;
            idx_q   <= '0;
          end
        end
        SCAN: begin
          if (idx_q == LAST_IDX) begin
            state_q <= tick ? SCAN : IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_parameter_bank.sv
// Randomized scoreboard bench for parameter_bank: events are checked in order by a monitor,
// parameters against a target-only model at settle points and one cycle after each accept.
module tb_parameter_bank;
  import parameter_bank_pkg::*;

  localparam int NCH  = 4;
  localparam int STEP = 4;
  localparam int DIV  = 8;

  localparam parameter_t DEF = '{
    volume: 8'h40, unison_detune: 8'h00, attack_time: 8'h00, decay_time: 8'h00,
    sustain_level: 8'h7F, release_time: 8'h00, duty_cycle: 8'h40
  };

  typedef struct packed {
    logic [3:0]        ch;
    parameter_change_t p;
  } ev_t;

  logic clock = 1'b0;
  logic reset;
  parameter_t [NCH-1:0] params;
  parameter_bank_if bus();

  parameter_bank #(.NUM_CHANNELS(NCH), .SLEW_STEP(STEP), .SLEW_DIV(DIV)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .params (params)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  ev_t exp_q[$];
  ev_t exp_ev;
  ev_t held;
  logic held_v = 1'b0;
  parameter_t model[NCH];
  logic rnd_ready = 1'b0;
  logic trace_en = 1'b0;
  field_t last_vol;
  field_t trace_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pop one expected event per handshake, and require hold while stalled.
  always @(negedge clock) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("event_hold_valid", 64'(bus.change_valid), 64'd1);
        check("event_hold_data", 64'({bus.change_channel, bus.change_param}), 64'(held));
      end
      if (bus.change_valid && bus.change_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL event_unexpected: got ch %0d param %0d, none expected",
                   bus.change_channel, bus.change_param);
        end else begin
          exp_ev = exp_q.pop_front();
          check("event", 64'({bus.change_channel, bus.change_param}), 64'(exp_ev));
        end
      end
      held_v = bus.change_valid && !bus.change_ready;
      held   = '{ch: bus.change_channel, p: bus.change_param};
    end
  end

  always @(negedge clock) begin
    if (trace_en && params[1].volume != last_vol) begin
      trace_q.push_back(params[1].volume);
      last_vol = params[1].volume;
    end
  end

  always @(posedge clock) begin
    #1;
    if (rnd_ready) bus.change_ready = 1'($urandom_range(0, 1));
  end

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) model[c] = DEF;
  endtask

  task automatic model_accept(input logic [3:0] ch, input logic [6:0] num, input logic [6:0] val);
    field_t v;
    int ci;
    v  = {1'b0, val};
    ci = int'(ch);
    if (ci < NCH) begin
      case (int'(num))
        121: begin model[ci] = DEF;              exp_q.push_back('{ch: ch, p: PARAM_NONE}); end
        7:   begin model[ci].volume = v;         exp_q.push_back('{ch: ch, p: PARAM_VOLUME}); end
        94:  begin model[ci].unison_detune = v;  exp_q.push_back('{ch: ch, p: PARAM_UNISON_DETUNE}); end
        73:  begin model[ci].attack_time = v;    exp_q.push_back('{ch: ch, p: PARAM_ATTACK_TIME}); end
        75:  begin model[ci].decay_time = v;     exp_q.push_back('{ch: ch, p: PARAM_DECAY_TIME}); end
        79:  begin model[ci].sustain_level = v;  exp_q.push_back('{ch: ch, p: PARAM_SUSTAIN_LEVEL}); end
        72:  begin model[ci].release_time = v;   exp_q.push_back('{ch: ch, p: PARAM_RELEASE_TIME}); end
        70:  begin model[ci].duty_cycle = v;     exp_q.push_back('{ch: ch, p: PARAM_DUTY_CYCLE}); end
        default: ;
      endcase
    end
  endtask

  task automatic send_cc(input logic [3:0] ch, input logic [6:0] num, input logic [6:0] val);
    logic seen;
    int waited;
    seen   = 1'b0;
    waited = 0;
    @(posedge clock);
    #1;
    bus.cc_valid   = 1'b1;
    bus.cc_channel = ch;
    bus.cc_number  = num;
    bus.cc_value   = val;
    while (!seen && waited <= 200) begin
      @(negedge clock);
      seen = bus.cc_ready;
      @(posedge clock);
      #1;
      waited++;
    end
    if (seen) model_accept(ch, num, val);
    else begin
      n_vec++;
      n_err++;
      $display("FAIL cc_accept_timeout: cc_ready stayed 0, required 1");
    end
    bus.cc_valid = 1'b0;
  endtask

  task automatic check_static(input string tag);
    for (int c = 0; c < NCH; c++)
      check($sformatf("%s_ch%0d", tag, c),
            64'({params[c].unison_detune, params[c].attack_time, params[c].decay_time, params[c].release_time}),
            64'({model[c].unison_detune, model[c].attack_time, model[c].decay_time, model[c].release_time}));
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NCH; c++)
      check($sformatf("%s_ch%0d", tag, c), 64'(params[c]), 64'(model[c]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rch;
    logic [6:0] rnum, rval;
    int cc_tab[9] = '{7, 94, 73, 75, 79, 72, 70, 121, 10};
    int k_pick, w;
    field_t exp_v;

    bus.cc_valid = 1'b0;
    bus.cc_channel = '0;
    bus.cc_number = '0;
    bus.cc_value = '0;
    bus.change_ready = 1'b1;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("cc_ready_in_reset", 64'(bus.cc_ready), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("cc_ready_after_reset", 64'(bus.cc_ready), 64'd1);
    check("change_valid_after_reset", 64'(bus.change_valid), 64'd0);
    check_all("reset");

    // Glide of ch1 volume 0x40 -> 0x7F in steps of 4, no overshoot.
    last_vol = 8'h40;
    trace_en = 1'b1;
    send_cc(4'd1, 7'd7, 7'h7F);
    repeat (200) @(posedge clock);
    trace_en = 1'b0;
    check("slew_trace_len", 64'(trace_q.size()), 64'd16);
    for (int k = 0; k < trace_q.size() && k < 16; k++) begin
      exp_v = (8'h40 + 8'(4 * (k + 1)) > 8'h7F) ? 8'h7F : 8'h40 + 8'(4 * (k + 1));
      check($sformatf("slew_step_%0d", k), 64'(trace_q[k]), 64'(exp_v));
    end
    @(negedge clock);
    check_all("after_slew");

    send_cc(4'd2, 7'd73, 7'h30);
    @(negedge clock);
    check("attack_t_plus_1", 64'(params[2].attack_time), 64'h30);

    send_cc(4'd0, 7'd10, 7'h55);
    send_cc(4'd5, 7'd7, 7'h11);
    @(negedge clock);
    check("unmapped_no_event", 64'(bus.change_valid), 64'd0);
    check_all("unmapped");

    // Backpressure: second CC must wait until the pending event drains.
    @(posedge clock);
    #1 bus.change_ready = 1'b0;
    send_cc(4'd3, 7'd94, 7'h22);
    fork
      send_cc(4'd3, 7'd70, 7'h10);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          check("cc_ready_blocked", 64'(bus.cc_ready), 64'd0);
        end
        @(posedge clock);
        #1 bus.change_ready = 1'b1;
      end
    join
    @(negedge clock);
    check_static("backpressure");

    // Reset-all during a glide on ch3.
    send_cc(4'd3, 7'd7, 7'h7F);
    w = 0;
    while (params[3].volume != 8'h60 && w < 500) begin
      @(negedge clock);
      w++;
    end
    check("glide_reaches_60", 64'(params[3].volume), 64'h60);
    send_cc(4'd3, 7'd121, 7'h00);
    @(negedge clock);
    check("reset_all_volume", 64'(params[3].volume), 64'h40);
    check_all("reset_all");
    repeat (100) @(posedge clock);
    @(negedge clock);
    check("no_slew_after_reset_all", 64'(params[3].volume), 64'h40);
    check_all("after_slew_converged");

    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rch    = 4'($urandom_range(0, 5));
      k_pick = int'($urandom_range(0, 9));
      rnum   = (k_pick < 9) ? 7'(cc_tab[k_pick]) : 7'($urandom_range(0, 127));
      rval   = 7'($urandom_range(0, 127));
      send_cc(rch, rnum, rval);
      @(negedge clock);
      check_static($sformatf("rand_static_%0d", i));
      if (rnum == 7'd121 && int'(rch) < NCH)
        check($sformatf("rand_reset_all_%0d", i), 64'(params[rch[1:0]]), 64'(DEF));
    end
    rnd_ready = 1'b0;
    @(posedge clock);
    #1 bus.change_ready = 1'b1;
    repeat (400) @(posedge clock);
    @(negedge clock);
    check_all("rand_converged");
    check("events_drained", 64'(exp_q.size()), 64'd0);

    // Reset while an event is pending discards it.
    @(posedge clock);
    #1 bus.change_ready = 1'b0;
    send_cc(4'd2, 7'd79, 7'h05);
    @(negedge clock);
    check("pending_before_reset", 64'(bus.change_valid), 64'd1);
    @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    bus.change_ready = 1'b1;
    @(negedge clock);
    check("pending_dropped", 64'(bus.change_valid), 64'd0);
    check_all("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/parameter_bank.md
# parameter_bank

Multi-channel synthesis parameter store that sits between the MIDI decoder and the voice engines. It accepts MIDI control-change (CC) events, maps controller numbers onto `PARAMETER::parameter_change_t`, and keeps one `PARAMETER::parameter_t` per MIDI channel. Level-type fields (volume, sustain level, duty cycle) glide toward their targets at a programmable rate to avoid zipper noise. Each accepted change is reported on a backpressured change-event stream.

## Interface
- `NUM_CHANNELS`, 4: independent parameter sets, 1..16.
- `SLEW_STEP`, 4: max per-tick change of a slewed field, 1..127.
- `SLEW_DIV`, 256: clock cycles per slew tick; must be >= `NUM_CHANNELS` (elaboration assertion).
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cc_valid`  in  1  CC event present.
- `cc_ready`  out  1  CC event accepted when `cc_valid && cc_ready`.
- `cc_channel`  in  4  MIDI channel.
- `cc_number`  in  `MIDI::DATA_WIDTH`  controller number.
- `cc_value`  in  `MIDI::DATA_WIDTH`  controller value.
- `params`  out  `NUM_CHANNELS` x `parameter_t`  current (smoothed) parameters.
- `change_valid`  out  1  change event pending.
- `change_ready`  in  1  consumer accepts the change event.
- `change_channel`  out  4  channel of the change.
- `change_param`  out  `parameter_change_t`  field changed; `PARAM_NONE` means all fields were restored to defaults.

## Operation
- CC map: 7 volume, 94 unison_detune, 73 attack_time, 75 decay_time, 79 sustain_level, 72 release_time, 70 duty_cycle, 121 reset-all-controllers. Any other number, or `cc_channel >= NUM_CHANNELS`: accepted, no state change, no event.
- Per channel, two register sets: target and current. A mapped CC writes the target field.
- Non-slewed fields (unison_detune, attack/decay/release times) are written to target and current at the same time.
- CC 121 loads `DEFAULT_PARAMETERS` into target and current of that channel. This is immediate and bypasses slewing. It raises an event with `change_param = PARAM_NONE`.
- Change event: one-entry output register. `cc_ready = !change_valid || change_ready`. An accepted mapped CC loads the register in the same cycle the old entry drains.
- Slew divider: counts 0..`SLEW_DIV`-1 and issues a one-cycle `tick` at wrap.
- Slew FSM, two states:
  - IDLE: on `tick`, go to SCAN with idx=0.
  - SCAN: on channel idx, update volume, sustain_level and duty_cycle in parallel, then idx++. After idx = `NUM_CHANNELS`-1, return to IDLE.
- Step rule, per slewed field, computed at 8 bits:
  - if cur < tgt: cur += min(`SLEW_STEP`, tgt-cur)
  - if cur > tgt: cur -= min(`SLEW_STEP`, cur-tgt)
  - otherwise unchanged. No overshoot, no wrap.
- Same-cycle CC write and SCAN of the same channel: the scan uses the old target, and the new target is stored. CC 121 takes priority over the scan update of current.

## Timing
- Reset: every target and current = `DEFAULT_PARAMETERS`. `change_valid`=0. `cc_ready`=0 during reset and 1 in the first cycle after reset. Divider=0, FSM=IDLE.
- CC accepted in cycle t:
  - target updated at t+1
  - non-slewed fields and CC 121 effects visible on `params` at t+1
  - `change_valid` high at t+1
- Slewed field latency: first movement within `SLEW_DIV`+`NUM_CHANNELS` cycles. Full convergence after ceil(|tgt-cur|/`SLEW_STEP`) ticks.
- `change_*` outputs stay stable while `change_valid && !change_ready`.
- Reset mid-scan aborts the scan. Reset during a pending event discards it.

## Structure
- Add to `PARAMETER`:
  - CC number constants (`CC_VOLUME` ... `CC_RESET_ALL`)
  - a `cc_to_param` function returning `parameter_change_t`
  - `slew_state_t` enum {IDLE, SCAN}
- One sub-module, `param_slew`: a combinational single-field step with `SLEW_STEP` parameter, inputs cur/tgt, output next. Instantiate three times.

## Test plan
- Reset → all channels equal `DEFAULT_PARAMETERS` (volume 0x40, sustain 0x7F, duty 0x40, times 0). `change_valid`=0, `cc_ready`=1 after reset.
- STEP=4, DIV=8: CC7=0x7F on ch1 → volume 0x44, 0x48, …, 0x7C, 0x7F over 16 ticks with no overshoot. One event (ch1, PARAM_VOLUME). Ch0 unchanged.
- CC73=0x30 on ch2 → attack_time=0x30 exactly one cycle after accept. Event (ch2, PARAM_ATTACK_TIME).
- CC10, and CC7 on channel 5 with NUM_CHANNELS=4 → both accepted, no event, `params` unchanged.
- `change_ready`=0 with one event pending, second CC offered → `cc_ready`=0, CC held. After `change_ready`=1, second event appears next cycle and both events are delivered in order.
- Volume mid-glide at 0x60 → CC121 → volume 0x40 next cycle, no further slewing. Event (ch, PARAM_NONE).
